// File: rtl/am2940_command_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// am2940_command_sequencer_pkg
// Shared definitions for the Am2940 command sequencer and its decoder:
// instruction and control word lengths, the Am2940 instruction opcodes,
// and the sequencer state encodings.
// Configuration macro: AUTO_REINIT_EN (the REINIT state encoding is always
// defined here; only the sequencer decides whether it is reachable).
// ---------------------------------------------------------------------------
package am2940_command_sequencer_pkg;

   localparam int INSTR_LENGTH = 3;
   localparam int CTRL_LENGTH  = 3;

   // Am2940 instruction set as seen on I[2:0]
   typedef enum logic [INSTR_LENGTH-1:0] {
      OP_WRCR   = 3'd0,
      OP_RDCR   = 3'd1,
      OP_RDWC   = 3'd2,
      OP_RDAC   = 3'd3,
      OP_REINIT = 3'd4,
      OP_LDAR   = 3'd5,
      OP_LDWC   = 3'd6,
      OP_ENCT   = 3'd7
   } am2940_op_t;

   // Sequencer state encodings, kept as plain constants so older
   // decoder logic can compare against them directly
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_WRCR   = 3'd1;
   localparam logic [STATE_W-1:0] ST_LDAR   = 3'd2;
   localparam logic [STATE_W-1:0] ST_LDWC   = 3'd3;
   localparam logic [STATE_W-1:0] ST_XFER   = 3'd4;
   localparam logic [STATE_W-1:0] ST_REINIT = 3'd5;

endpackage

// File: rtl/am2940_command_sequencer_if.sv
// ---------------------------------------------------------------------------
// am2940_command_sequencer_if
// Bundles the descriptor handshake, the beat handshake, the Am2940
// instruction/data bus and the status pulses of the command sequencer.
//   slave  : view of the sequencer itself
//   master : view of the channel controller / Am2940 side driving it
// Signals:
//   desc_valid/desc_ready, desc_ctrl[2:0], desc_addr, desc_wc, desc_repeat
//   abort, dreq/dack, done_in
//   instr_out[2:0], data_out, data_oe
//   busy, cmplt, aborted
// Configuration macro: AUTO_REINIT_EN (desc_repeat only matters when set).
// ---------------------------------------------------------------------------
interface am2940_command_sequencer_if #(parameter int DATA_W = 8);
   import am2940_command_sequencer_pkg::*;

   logic                    desc_valid;
   logic                    desc_ready;
   logic [CTRL_LENGTH-1:0]  desc_ctrl;
   logic [DATA_W-1:0]       desc_addr;
   logic [DATA_W-1:0]       desc_wc;
   logic                    desc_repeat;
   logic                    abort;
   logic                    dreq;
   logic                    dack;
   logic                    done_in;
   logic [INSTR_LENGTH-1:0] instr_out;
   logic [DATA_W-1:0]       data_out;
   logic                    data_oe;
   logic                    busy;
   logic                    cmplt;
   logic                    aborted;

   modport slave (
      input  desc_valid, desc_ctrl, desc_addr, desc_wc, desc_repeat,
      input  abort, dreq, done_in,
      output desc_ready, dack, instr_out, data_out, data_oe,
      output busy, cmplt, aborted
   );

   modport master (
      output desc_valid, desc_ctrl, desc_addr, desc_wc, desc_repeat,
      output abort, dreq, done_in,
      input  desc_ready, dack, instr_out, data_out, data_oe,
      input  busy, cmplt, aborted
   );

endinterface

// File: rtl/am2940_command_sequencer.sv
// ---------------------------------------------------------------------------
// am2940_command_sequencer
// Accepts a transfer descriptor, programs the Am2940 with WRCR, LDAR and
// LDWC (one cycle each), then issues one ENCT per granted data beat until
// the Am2940 reports DONE or the transfer is aborted.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : am2940_command_sequencer_if.slave (descriptor handshake,
//              beat handshake, Am2940 instruction/data bus, status pulses)
// Parameter:
//   DATA_W   : Am2940 data bus / address / word count width (default 8)
// Configuration macro:
//   AUTO_REINIT_EN : when defined, a descriptor with desc_repeat set loops
//                    through REINIT after every DONE until aborted.
// ---------------------------------------------------------------------------
module am2940_command_sequencer
   import am2940_command_sequencer_pkg::*;
#(
   parameter int DATA_W = 8
)
(
   input logic clk,
   input logic reset_n,
   am2940_command_sequencer_if.slave bus
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [DATA_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wc_q;
   logic [DATA_W-1:0]  data_q;
   am2940_op_t         instr_q;
   logic               oe_q;
   logic               busy_q;
   logic               cmplt_q;
   logic               aborted_q;
   logic               ready_q;
   logic               beat_prev_q;
   logic               accept;
   logic               abort_hit;
   logic               beat;
   logic               done_hit;

   // The ENCT grant is qualified in the same cycle as dreq, done_in and
   // abort so the Am2940 never sees a count pulse past DONE or on an abort
   // cycle; everything else comes straight from registers.
   assign accept    = (state_q == ST_IDLE) && ready_q && bus.desc_valid;
   assign abort_hit = (state_q != ST_IDLE) && bus.abort;
   assign beat      = (state_q == ST_XFER) && bus.dreq && !bus.done_in && !bus.abort;

   // DONE is trusted only when no ENCT went out in the previous cycle,
   // giving the Am2940 word counter a cycle to settle.
   assign done_hit  = (state_q == ST_XFER) && !bus.abort && bus.done_in && !beat_prev_q;

`ifdef AUTO_REINIT_EN
   logic repeat_q;

   // Repeat request is captured with the rest of the descriptor
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         repeat_q <= 1'b0;
      end else if (accept) begin
         repeat_q <= bus.desc_repeat;
      end
   end
`else
   logic unused_repeat;
   assign unused_repeat = bus.desc_repeat;
`endif

   // Next-state logic: abort from any busy state wins over everything,
   // including a DONE arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = ST_WRCR;
      end else if (abort_hit) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_WRCR: state_d = ST_LDAR;
            ST_LDAR: state_d = ST_LDWC;
            ST_LDWC: state_d = ST_XFER;
            ST_XFER: begin
               if (done_hit) begin
`ifdef AUTO_REINIT_EN
                  state_d = repeat_q ? ST_REINIT : ST_IDLE;
`else
                  state_d = ST_IDLE;
`endif
               end
            end
`ifdef AUTO_REINIT_EN
            ST_REINIT: state_d = ST_XFER;
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, status and bus-drive registers; the bus value for a state is
   // loaded on the edge that enters it so it is stable for the whole cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         cmplt_q     <= 1'b0;
         aborted_q   <= 1'b0;
         beat_prev_q <= 1'b0;
         addr_q      <= '0;
         wc_q        <= '0;
         instr_q     <= OP_RDCR;
         data_q      <= '0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= (state_d == ST_IDLE);
         busy_q      <= (state_d != ST_IDLE);
         cmplt_q     <= done_hit;
         aborted_q   <= abort_hit;
         beat_prev_q <= beat;
         if (accept) begin
            addr_q <= bus.desc_addr;
            wc_q   <= bus.desc_wc;
         end
         case (state_d)
            ST_WRCR: begin
               instr_q <= OP_WRCR;
               data_q  <= DATA_W'(bus.desc_ctrl);
               oe_q    <= 1'b1;
            end
            ST_LDAR: begin
               instr_q <= OP_LDAR;
               data_q  <= addr_q;
               oe_q    <= 1'b1;
            end
            ST_LDWC: begin
               instr_q <= OP_LDWC;
               data_q  <= wc_q;
               oe_q    <= 1'b1;
            end
`ifdef AUTO_REINIT_EN
            ST_REINIT: begin
               instr_q <= OP_REINIT;
               data_q  <= '0;
               oe_q    <= 1'b0;
            end
`endif
            default: begin
               instr_q <= OP_RDCR;
               data_q  <= '0;
               oe_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.desc_ready = ready_q;
   assign bus.dack       = beat;
   assign bus.instr_out  = beat ? OP_ENCT : instr_q;
   assign bus.data_out   = data_q;
   assign bus.data_oe    = oe_q;
   assign bus.busy       = busy_q;
   assign bus.cmplt      = cmplt_q;
   assign bus.aborted    = aborted_q;

endmodule
